// File: rtl/imem_loader.sv
// Program loader: receives a length-prefixed, XOR-checksummed byte frame and writes it
// word by word into instruction memory while holding the core stalled.
module imem_loader #(
   parameter int                    DATA_WIDTH = 32,
   parameter int                    ADDR_WIDTH = 32,
   parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
   parameter int                    MAX_WORDS  = 256
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic                  in_valid,
   input  logic [7:0]            in_data,
   output logic                  in_ready,
   output logic                  imem_we,
   output logic [ADDR_WIDTH-1:0] imem_addr,
   output logic [DATA_WIDTH-1:0] imem_wdata,
   output logic                  cpu_hold,
   output logic                  done,
   output logic                  err,
   output logic [15:0]           words_loaded
);

   // state  | meaning
   // IDLE   | waiting for start, core released
   // LEN_LO | expecting low byte of word count
   // LEN_HI | expecting high byte of word count
   // DATA   | packing data bytes into words, one write per 4 bytes
   // CSUM   | expecting XOR checksum byte
   // FIN    | done pulse, core still held
   typedef enum logic [2:0] {IDLE, LEN_LO, LEN_HI, DATA, CSUM, FIN} state_t;

   state_t                  state_q, state_d;
   logic [15:0]             len_q, len_d;
   logic [1:0]              idx_q, idx_d;
   logic [23:0]             buf_q, buf_d;
   logic [7:0]              csum_q, csum_d;
   logic [15:0]             words_q, words_d;
   logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
   logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
   logic                    we_q, we_d;
   logic                    err_q, err_d;
   logic                    hold_q, hold_d;

   logic                    accept;
   logic [15:0]             n_len;
   logic [15:0]             words_inc;
   logic [ADDR_WIDTH-1:0]   word_off;

   always_comb begin
      state_d = state_q;
      len_d   = len_q;
      idx_d   = idx_q;
      buf_d   = buf_q;
      csum_d  = csum_q;
      words_d = words_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      we_d    = 1'b0;
      err_d   = err_q;
      hold_d  = hold_q;

      in_ready  = (state_q == LEN_LO) || (state_q == LEN_HI) ||
                  (state_q == DATA)   || (state_q == CSUM);
      done      = (state_q == FIN);
      accept    = in_valid && in_ready;
      n_len     = {in_data, len_q[7:0]};
      words_inc = words_q + 16'd1;
      word_off  = ADDR_WIDTH'({words_q, 2'b00});

      case (state_q)
         IDLE: begin
            if (start) begin
               state_d = LEN_LO;
               hold_d  = 1'b1;
               err_d   = 1'b0;
               words_d = '0;
               csum_d  = '0;
               idx_d   = '0;
            end
         end
         LEN_LO: begin
            if (accept) begin
               len_d[7:0] = in_data;
               state_d    = LEN_HI;
            end
         end
         LEN_HI: begin
            if (accept) begin
               len_d = n_len;
               if (n_len == 16'd0) begin
                  state_d = CSUM;
               end else if (n_len > 16'(MAX_WORDS)) begin
                  // oversize frame: abandon without touching IMEM or the checksum byte
                  err_d   = 1'b1;
                  state_d = FIN;
               end else begin
                  state_d = DATA;
               end
            end
         end
         DATA: begin
            if (accept) begin
               csum_d = csum_q ^ in_data;
               idx_d  = idx_q + 2'd1;
               case (idx_q)
                  2'd0: buf_d[7:0]   = in_data;
                  2'd1: buf_d[15:8]  = in_data;
                  2'd2: buf_d[23:16] = in_data;
                  default: begin
                     wdata_d = {in_data, buf_q};
                     addr_d  = BASE_ADDR + word_off;
                     we_d    = 1'b1;
                     words_d = words_inc;
                     if (words_inc == len_q) state_d = CSUM;
                  end
               endcase
            end
         end
         CSUM: begin
            if (accept) begin
               if (in_data != csum_q) err_d = 1'b1;
               state_d = FIN;
            end
         end
         FIN: begin
            state_d = IDLE;
            hold_d  = 1'b0;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         len_q   <= '0;
         idx_q   <= '0;
         buf_q   <= '0;
         csum_q  <= '0;
         words_q <= '0;
         addr_q  <= BASE_ADDR;
         wdata_q <= '0;
         we_q    <= 1'b0;
         err_q   <= 1'b0;
         hold_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         len_q   <= len_d;
         idx_q   <= idx_d;
         buf_q   <= buf_d;
         csum_q  <= csum_d;
         words_q <= words_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         we_q    <= we_d;
         err_q   <= err_d;
         hold_q  <= hold_d;
      end
   end

   assign imem_we      = we_q;
   assign imem_addr    = addr_q;
   assign imem_wdata   = wdata_q;
   assign cpu_hold     = hold_q;
   assign err          = err_q;
   assign words_loaded = words_q;

endmodule

// File: tb/tb_imem_loader.sv
// Randomized bench for imem_loader: frames are scored against a frame-level model that
// derives the expected IMEM writes, error flag and consumed byte count from the frame bytes.
module tb_imem_loader;

   typedef logic [7:0] bytes_t [$];

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        start = 1'b0;
   logic        in_valid = 1'b0;
   logic [7:0]  in_data = '0;
   logic        in_ready;
   logic        imem_we;
   logic [31:0] imem_addr;
   logic [31:0] imem_wdata;
   logic        cpu_hold;
   logic        done;
   logic        err;
   logic [15:0] words_loaded;

   int vectors = 0;
   int miscompares = 0;

   logic [63:0] got_q [$];
   int          done_cnt = 0;
   logic        prev_done = 1'b0;
   logic        hold_at_done, err_at_done, hold_after, done_after;
   logic [15:0] words_at_done;

   imem_loader dut (
      .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_data(in_data),
      .in_ready(in_ready), .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
      .cpu_hold(cpu_hold), .done(done), .err(err), .words_loaded(words_loaded)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (imem_we) got_q.push_back({imem_addr, imem_wdata});
      if (prev_done) begin
         hold_after = cpu_hold;
         done_after = done;
      end
      if (done) begin
         done_cnt++;
         hold_at_done  = cpu_hold;
         err_at_done   = err;
         words_at_done = words_loaded;
      end
      prev_done = done;
   end

   task automatic run_frame(input string name, input bytes_t f, input int gap_pct);
      logic [63:0] exp_q [$];
      int          n, e_cons, idx, cyc, d0, hold_bad, limit;
      logic        e_err, acc;
      logic [7:0]  x;
      logic [31:0] w;

      n = int'(f[1]) * 256 + int'(f[0]);
      if (n > 256) begin
         e_err = 1'b1; e_cons = 2;
      end else begin
         x = '0;
         for (int i = 0; i < n; i++) begin
            w = {f[2+4*i+3], f[2+4*i+2], f[2+4*i+1], f[2+4*i]};
            exp_q.push_back({32'(4 * i), w});
            for (int k = 0; k < 4; k++) x = x ^ f[2+4*i+k];
         end
         e_cons = 2 + 4 * n + 1;
         e_err  = (f[2+4*n] != x);
      end

      got_q.delete();
      d0 = done_cnt;
      hold_bad = 0;
      limit = 40 * f.size() + 200;

      @(posedge clk); #1;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      @(negedge clk); #1;
      vectors++;
      if (err !== 1'b0 || words_loaded !== 16'd0 || cpu_hold !== 1'b1) begin
         miscompares++;
         $display("FAIL %s start: err=%b words=%0d hold=%b, need err=0 words=0 hold=1",
                  name, err, words_loaded, cpu_hold);
      end
      @(posedge clk); #1;

      idx = 0; cyc = 0;
      while (idx < f.size() && done_cnt == d0 && cyc < limit) begin
         in_valid = ($urandom_range(0, 99) >= gap_pct);
         in_data  = in_valid ? f[idx] : 8'($urandom);
         @(negedge clk); #1;
         acc = in_valid && in_ready;
         if (done_cnt == d0 && !cpu_hold) hold_bad++;
         @(posedge clk); #1;
         if (acc) idx++;
         cyc++;
      end
      in_valid = 1'b0;
      while (done_cnt == d0 && cyc < limit) begin
         @(negedge clk); #1;
         cyc++;
      end
      repeat (2) @(negedge clk);
      #1;

      vectors++;
      if (done_cnt - d0 != 1) begin
         miscompares++;
         $display("FAIL %s done_pulses: got %0d, need 1", name, done_cnt - d0);
      end
      vectors++;
      if (got_q.size() != exp_q.size()) begin
         miscompares++;
         $display("FAIL %s write_count: got %0d, need %0d", name, got_q.size(), exp_q.size());
      end
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
         vectors++;
         if (got_q[i] !== exp_q[i]) begin
            miscompares++;
            $display("FAIL %s write[%0d]: got addr=%h data=%h, need addr=%h data=%h", name, i,
                     got_q[i][63:32], got_q[i][31:0], exp_q[i][63:32], exp_q[i][31:0]);
         end
      end
      vectors++;
      if (err_at_done !== e_err) begin
         miscompares++;
         $display("FAIL %s err: got %b, need %b", name, err_at_done, e_err);
      end
      vectors++;
      if (words_at_done !== 16'(exp_q.size())) begin
         miscompares++;
         $display("FAIL %s words_loaded: got %0d, need %0d", name, words_at_done, exp_q.size());
      end
      vectors++;
      if (idx != e_cons) begin
         miscompares++;
         $display("FAIL %s bytes_consumed: got %0d, need %0d", name, idx, e_cons);
      end
      vectors++;
      if (hold_bad != 0 || hold_at_done !== 1'b1 || hold_after !== 1'b0 || done_after !== 1'b0) begin
         miscompares++;
         $display("FAIL %s hold: drops=%0d at_done=%b after=%b done_after=%b, need 0 1 0 0",
                  name, hold_bad, hold_at_done, hold_after, done_after);
      end
   endtask

   task automatic send_byte(input logic [7:0] b);
      logic acc;
      int   cyc;
      in_valid = 1'b1;
      in_data  = b;
      acc = 1'b0;
      cyc = 0;
      while (!acc && cyc < 50) begin
         @(negedge clk); #1;
         acc = in_ready;
         @(posedge clk); #1;
         cyc++;
      end
      in_valid = 1'b0;
      vectors++;
      if (!acc) begin
         miscompares++;
         $display("FAIL send_byte: byte %h never accepted, need acceptance within 50 cycles", b);
      end
   endtask

   function automatic bytes_t spec_frame(input logic [7:0] cs);
      bytes_t f;
      f = '{8'h02, 8'h00, 8'h93, 8'h00, 8'h50, 8'h00, 8'h13, 8'h01, 8'hC0, 8'h00};
      f.push_back(cs);
      return f;
   endfunction

   function automatic bytes_t rand_frame(input int n, input bit corrupt);
      bytes_t     f;
      logic [7:0] x, b;
      f.push_back(8'(n));
      f.push_back(8'(n >> 8));
      x = '0;
      for (int i = 0; i < 4 * n; i++) begin
         b = 8'($urandom);
         f.push_back(b);
         x = x ^ b;
      end
      f.push_back(corrupt ? ~x : x);
      return f;
   endfunction

   task automatic test_reset();
      reset = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      @(negedge clk); #1;
      vectors++;
      if ({in_ready, imem_we, cpu_hold, done, err} !== 5'b0 || imem_addr !== 32'h0 ||
          imem_wdata !== 32'h0 || words_loaded !== 16'h0) begin
         miscompares++;
         $display("FAIL reset_values: rdy=%b we=%b hold=%b done=%b err=%b addr=%h wd=%h wl=%0d, need all 0",
                  in_ready, imem_we, cpu_hold, done, err, imem_addr, imem_wdata, words_loaded);
      end
      @(posedge clk); #1;
      reset = 1'b0;
      got_q.delete();
      for (int i = 0; i < 10; i++) begin
         in_valid = i[0];
         in_data  = 8'($urandom);
         @(negedge clk); #1;
         vectors++;
         if (in_ready !== 1'b0 || cpu_hold !== 1'b0) begin
            miscompares++;
            $display("FAIL idle_ready: in_ready=%b hold=%b, need 0 0", in_ready, cpu_hold);
         end
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      vectors++;
      if (got_q.size() != 0) begin
         miscompares++;
         $display("FAIL idle_writes: got %0d, need 0", got_q.size());
      end
   endtask

   task automatic test_basic();
      run_frame("basic", spec_frame(8'h11), 0);
   endtask

   task automatic test_bad_csum();
      run_frame("bad_csum", spec_frame(8'h00), 0);
   endtask

   task automatic test_oversize();
      bytes_t f;
      f = '{8'h01, 8'h01, 8'h00};
      run_frame("oversize", f, 0);
   endtask

   task automatic test_zero_len();
      bytes_t f;
      f = '{8'h00, 8'h00, 8'h00};
      run_frame("zero_len", f, 0);
   endtask

   task automatic test_gaps();
      run_frame("gaps_spec", spec_frame(8'h11), 50);
      for (int i = 0; i < 6; i++)
         run_frame("gaps_rand", rand_frame($urandom_range(1, 6), bit'($urandom_range(0, 1))), 40);
   endtask

   task automatic test_boundary();
      run_frame("max_words", rand_frame(256, 1'b0), 0);
      run_frame("one_word", rand_frame(1, 1'b0), 10);
   endtask

   task automatic test_reset_mid();
      bytes_t f;
      f = spec_frame(8'h11);
      got_q.delete();
      @(posedge clk); #1;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      for (int i = 0; i < 7; i++) send_byte(f[i]);
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      @(negedge clk); #1;
      vectors++;
      if (words_loaded !== 16'd1 || cpu_hold !== 1'b1 || in_ready !== 1'b1) begin
         miscompares++;
         $display("FAIL start_ignored: words=%0d hold=%b rdy=%b, need 1 1 1",
                  words_loaded, cpu_hold, in_ready);
      end
      @(posedge clk); #1;
      reset = 1'b1;
      @(posedge clk); #1;
      @(negedge clk); #1;
      vectors++;
      if (cpu_hold !== 1'b0 || in_ready !== 1'b0 || imem_addr !== 32'h0 || words_loaded !== 16'd0 ||
          imem_we !== 1'b0 || done !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_mid: hold=%b rdy=%b addr=%h words=%0d we=%b done=%b, need 0 0 0 0 0 0",
                  cpu_hold, in_ready, imem_addr, words_loaded, imem_we, done);
      end
      vectors++;
      if (got_q.size() != 1 || (got_q.size() == 1 && got_q[0] !== {32'h0, 32'h00500093})) begin
         miscompares++;
         $display("FAIL reset_mid_writes: got %0d writes, need 1 write of 00500093 at 0", got_q.size());
      end
      @(posedge clk); #1;
      reset = 1'b0;
   endtask

   initial begin
      test_reset();
      test_basic();
      test_bad_csum();
      test_oversize();
      test_zero_len();
      test_gaps();
      test_boundary();
      test_reset_mid();
      run_frame("after_reset", spec_frame(8'h11), 20);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
